led_mode_ctrl: RTL

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl.sv | 65 ++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: four-mode LED pattern controller (off, on, 1 Hz blink, quarter-second chase) with pause
module led_mode_ctrl #(
    parameter int CNT_1S = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_next,
    input  logic       key_pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       paused
);
    typedef enum logic [1:0] {OFF = 2'd0, ON = 2'd1, BLINK = 2'd2, CHASE = 2'd3} mode_e;

    localparam logic [31:0] LAST = 32'(CNT_1S - 1);
    localparam logic [31:0] HALF = 32'(CNT_1S / 2);
    localparam logic [31:0] Q1   = 32'(CNT_1S / 4 - 1);
    localparam logic [31:0] Q2   = 32'(CNT_1S / 2 - 1);
    localparam logic [31:0] Q3   = 32'(3 * CNT_1S / 4 - 1);

    mode_e       mode_q, mode_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  pos_q, pos_d;
    logic        paused_q, paused_d;
    logic [3:0]  led_q, led_d;
    logic        animated, step, quarter;

    // Next state; outputs are derived from next-state values so a key edge already shows the new pattern.
    // The timer advances only on edges where the pattern is running afterwards, so a resume edge counts.
    always_comb begin
        animated = (mode_q == BLINK) || (mode_q == CHASE);
        mode_d   = key_next ? mode_e'(mode_q + 2'd1) : mode_q;
        paused_d = key_next ? 1'b0 : paused_q ^ (key_pause & animated);
        step     = !key_next && animated && !paused_d;
        quarter  = (timer_q == Q1) || (timer_q == Q2) || (timer_q == Q3) || (timer_q == LAST);
        timer_d  = (key_next || !animated) ? 32'd0 :
                   step ? ((timer_q == LAST) ? 32'd0 : timer_q + 32'd1) : timer_q;
        pos_d    = key_next ? 2'd0 : (step && quarter) ? pos_q + 2'd1 : pos_q;
        led_d    = (mode_d == OFF)   ? 4'b0000 :
                   (mode_d == ON)    ? 4'b1111 :
                   (mode_d == BLINK) ? ((timer_d < HALF) ? 4'b1111 : 4'b0000) :
                                       4'b0001 << pos_d;
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= OFF;
            timer_q  <= 32'd0;
            pos_q    <= 2'd0;
            paused_q <= 1'b0;
            led_q    <= 4'b0000;
        end else begin
            mode_q   <= mode_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            paused_q <= paused_d;
            led_q    <= led_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;
endmodule
